// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if
//
// Bundles the decode-side bus of the multi-port register file: the read
// ports, both write ports, the busy-allocation request and the ready flag.
//
//   ready      : array has been zero-filled and normal operation is running
//   raddr      : NRD packed read addresses, port k at [k*RFW +: RFW]
//   rdata      : NRD packed read data words, port k at [k*DW +: DW]
//   rbusy      : per read port, addressed register has a pending writeback
//   we0/1      : write enables (port 1 is the older stage and wins on conflict)
//   waddr0/1   : write addresses
//   wdata0/1   : write data
//   alloc      : mark alloc_reg busy (a producing instruction was issued)
//   alloc_reg  : register to mark busy
//
// master : the pipeline side that drives addresses, writes and allocations
// slave  : the register file itself
// ----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int RFW = 5,
    parameter int DW  = 32,
    parameter int NRD = 2
);
    logic                 ready;
    logic [NRD*RFW-1:0]   raddr;
    logic [NRD*DW-1:0]    rdata;
    logic [NRD-1:0]       rbusy;
    logic                 we0;
    logic                 we1;
    logic [RFW-1:0]       waddr0;
    logic [RFW-1:0]       waddr1;
    logic [DW-1:0]        wdata0;
    logic [DW-1:0]        wdata1;
    logic                 alloc;
    logic [RFW-1:0]       alloc_reg;

    modport master (
        input  ready, rdata, rbusy,
        output raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, alloc, alloc_reg
    );

    modport slave (
        output ready, rdata, rbusy,
        input  raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, alloc, alloc_reg
    );
endinterface

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
//
// Multi-port integer register file for the decode stage. NRD combinational
// read ports, two posedge write ports with same-cycle write-to-read bypass,
// a per-register busy scoreboard, and a post-reset sweep that zero-fills the
// array so no register ever reads X. Register 0 is hardwired to zero.
//
// Ports:
//   clk    : core clock, all state updates on posedge
//   rst_n  : asynchronous active-low reset (restarts the zero-fill sweep)
//   rf     : regfile_mp_if.slave bus (reads, writes, alloc, ready)
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int RFW = 5,
    parameter int DW  = 32,
    parameter int NRD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   rf
);

    localparam int DEPTH = 1 << RFW;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [RFW-1:0]       cnt;
    logic                 sweep_en;
    logic                 run_en;

    logic [DW-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_nxt;

    logic                 wr0_en;
    logic                 wr1_en;
    logic                 alloc_en;

    logic [NRD*DW-1:0]    rdata_c;
    logic [NRD-1:0]       rbusy_c;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The sweep leaves INIT on the edge that clears the
    // last entry, so ready is high right after that edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (cnt == {RFW{1'b1}}) state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        sweep_en = 1'b0;
        run_en   = 1'b0;
        case (state)
            INIT: sweep_en = 1'b1;
            RUN:  run_en   = 1'b1;
            default: sweep_en = 1'b1;
        endcase
    end

    assign rf.ready = run_en;

    // ------------------------------------------------------------------
    // Sweep counter: one entry per cycle while in INIT
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sweep_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Writes and allocations only count in RUN and never touch register 0.
    assign wr0_en   = run_en && rf.we0   && (rf.waddr0    != '0);
    assign wr1_en   = run_en && rf.we1   && (rf.waddr1    != '0);
    assign alloc_en = run_en && rf.alloc && (rf.alloc_reg != '0);

    // ------------------------------------------------------------------
    // Storage array. Deliberately not reset: the sweep clears it. Port 1
    // is assigned last so it wins when both ports hit the same entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0_en) mem[rf.waddr0] <= rf.wdata0;
            if (wr1_en) mem[rf.waddr1] <= rf.wdata1;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. Writes clear, alloc sets; alloc is applied last so a
    // newer producer keeps the register busy when both land together.
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy;
        if (wr0_en)   busy_nxt[rf.waddr0]    = 1'b0;
        if (wr1_en)   busy_nxt[rf.waddr1]    = 1'b0;
        if (alloc_en) busy_nxt[rf.alloc_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with bypass. Port 1 bypass takes priority, matching the
    // write ordering above. A bypassed write hides the busy bit unless an
    // alloc is re-marking the same register this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic [RFW-1:0] a;
        logic           hit0;
        logic           hit1;
        logic           ahit;
        logic [DW-1:0]  d;
        a       = '0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        ahit    = 1'b0;
        d       = '0;
        rdata_c = '0;
        rbusy_c = '0;
        for (int k = 0; k < NRD; k++) begin
            a    = rf.raddr[k*RFW +: RFW];
            hit1 = rf.we1   && (rf.waddr1    == a);
            hit0 = rf.we0   && (rf.waddr0    == a);
            ahit = rf.alloc && (rf.alloc_reg == a);
            if (hit1) begin
                d = rf.wdata1;
            end else if (hit0) begin
                d = rf.wdata0;
            end else begin
                d = mem[a];
            end
            if (run_en && (a != '0)) begin
                rdata_c[k*DW +: DW] = d;
                rbusy_c[k]          = busy[a] && !((hit0 || hit1) && !ahit);
            end
        end
    end

    assign rf.rdata = rdata_c;
    assign rf.rbusy = rbusy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
//
// Directed bench for regfile_mp (RFW=5, DW=32, NRD=2). A behavioural model
// of the register file (plain arrays plus a ready flag) runs alongside the
// DUT and a compare process checks ready, rdata and rbusy on every falling
// edge. Hand-computed literal checks pin the key scenarios.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int RFW   = 5;
    localparam int DW    = 32;
    localparam int NRD   = 2;
    localparam int DEPTH = 1 << RFW;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    regfile_mp_if #(.RFW(RFW), .DW(DW), .NRD(NRD)) bus ();

    regfile_mp #(.RFW(RFW), .DW(DW), .NRD(NRD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_ready;
    int            m_edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0;
            m_edges <= 0;
            for (int i = 0; i < DEPTH; i++) m_busy[i] <= 1'b0;
        end else if (!m_ready) begin
            // After 2**RFW edges the whole array is known to be zero.
            if (m_edges == DEPTH - 1) begin
                m_ready <= 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            end
            m_edges <= m_edges + 1;
        end else begin
            if (bus.we0 && bus.waddr0 != 0) begin
                m_mem[bus.waddr0]  <= bus.wdata0;
                m_busy[bus.waddr0] <= 1'b0;
            end
            if (bus.we1 && bus.waddr1 != 0) begin
                m_mem[bus.waddr1]  <= bus.wdata1;
                m_busy[bus.waddr1] <= 1'b0;
            end
            if (bus.alloc && bus.alloc_reg != 0) m_busy[bus.alloc_reg] <= 1'b1;
        end
    end

    function automatic logic [DW-1:0] exp_rdata(input int a);
        if (!m_ready || a == 0) return '0;
        if (bus.we1 && bus.waddr1 == a) return bus.wdata1;
        if (bus.we0 && bus.waddr0 == a) return bus.wdata0;
        return m_mem[a];
    endfunction

    function automatic logic exp_rbusy(input int a);
        bit wr;
        bit al;
        if (!m_ready || a == 0) return 1'b0;
        wr = (bus.we1 && bus.waddr1 == a) || (bus.we0 && bus.waddr0 == a);
        al = bus.alloc && bus.alloc_reg == a;
        if (wr && !al) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int a;
        check("model_ready", {31'b0, bus.ready}, {31'b0, m_ready});
        for (int k = 0; k < NRD; k++) begin
            a = int'(bus.raddr[k*RFW +: RFW]);
            check("model_rdata", bus.rdata[k*DW +: DW], exp_rdata(a));
            check("model_rbusy", {31'b0, bus.rbusy[k]}, {31'b0, exp_rbusy(a)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we0 = 0; bus.we1 = 0; bus.alloc = 0;
        bus.waddr0 = 0; bus.waddr1 = 0; bus.alloc_reg = 0;
        bus.wdata0 = 0; bus.wdata1 = 0;
    endtask

    task automatic set_raddr(input int p0, input int p1);
        bus.raddr[0 +: RFW]   = RFW'(p0);
        bus.raddr[RFW +: RFW] = RFW'(p1);
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return bus.rdata[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rb(input int k);
        return {31'b0, bus.rbusy[k]};
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        idle();
        set_raddr(0, 0);
        repeat (3) tick();
        check("reset_ready", {31'b0, bus.ready}, 32'd0);
        check("reset_rbusy", {30'b0, bus.rbusy}, 32'd0);

        // Sweep: ready low through 31 edges, high after the 32nd.
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            set_raddr(i % DEPTH, 3);
            tick();
            if (i == 31) check("sweep_ready_31", {31'b0, bus.ready}, 32'd0);
            if (i == 32) check("sweep_ready_32", {31'b0, bus.ready}, 32'd1);
        end
        for (int i = 1; i < DEPTH; i++) begin
            set_raddr(i, DEPTH - i);
            #1;
            check("sweep_zero", rd(0), 32'h0000_0000);
        end

        // Basic write with bypass, then from the array.
        set_raddr(5, 0);
        bus.we0 = 1; bus.waddr0 = 5; bus.wdata0 = 32'hDEADBEEF;
        #1 check("bypass_r5", rd(0), 32'hDEADBEEF);
        tick();
        idle();
        #1 check("array_r5", rd(0), 32'hDEADBEEF);

        // Port priority on r7.
        set_raddr(7, 5);
        bus.we0 = 1; bus.waddr0 = 7; bus.wdata0 = 32'h11111111;
        bus.we1 = 1; bus.waddr1 = 7; bus.wdata1 = 32'h22222222;
        #1 check("prio_bypass_r7", rd(0), 32'h22222222);
        tick();
        idle();
        #1 check("prio_array_r7", rd(0), 32'h22222222);
        check("r5_kept", rd(1), 32'hDEADBEEF);

        // Zero register ignores writes and allocs.
        set_raddr(0, 0);
        bus.we1 = 1; bus.waddr1 = 0; bus.wdata1 = 32'hFFFFFFFF;
        bus.alloc = 1; bus.alloc_reg = 0;
        #1 check("r0_rdata_same", rd(0), 32'h0);
        check("r0_rbusy_same", rb(1), 32'h0);
        tick();
        idle();
        #1 check("r0_rdata_next", rd(1), 32'h0);
        check("r0_rbusy_next", rb(0), 32'h0);

        // Scoreboard on r9.
        set_raddr(0, 9);
        bus.alloc = 1; bus.alloc_reg = 9;
        #1 check("sb_alloc_same", rb(1), 32'h0);
        tick();
        idle();
        #1 check("sb_alloc_next", rb(1), 32'h1);
        bus.we0 = 1; bus.waddr0 = 9; bus.wdata0 = 32'h000000A5;
        bus.alloc = 1; bus.alloc_reg = 9;
        #1 check("sb_wr_alloc_same", rb(1), 32'h1);
        tick();
        idle();
        #1 check("sb_wr_alloc_next", rb(1), 32'h1);
        check("sb_r9_data", rd(1), 32'h000000A5);
        bus.we1 = 1; bus.waddr1 = 9; bus.wdata1 = 32'h0000005A;
        #1 check("sb_wr_bypass", rb(1), 32'h0);
        tick();
        idle();
        #1 check("sb_wr_cleared", rb(1), 32'h0);

        // Mid-operation reset with r9 busy and r3 holding data.
        bus.we0 = 1; bus.waddr0 = 3; bus.wdata0 = 32'h00001234;
        bus.alloc = 1; bus.alloc_reg = 9;
        tick();
        idle();
        set_raddr(3, 9);
        #1 check("pre_rst_r3", rd(0), 32'h00001234);
        check("pre_rst_busy9", rb(1), 32'h1);
        check("pre_rst_ready", {31'b0, bus.ready}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1 check("rst_ready_drop", {31'b0, bus.ready}, 32'd0);
        check("rst_busy_drop", rb(1), 32'h0);
        check("rst_rdata_zero", rd(0), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (DEPTH) tick();
        check("resweep_ready", {31'b0, bus.ready}, 32'd1);
        check("resweep_r3", rd(0), 32'h0);
        check("resweep_busy9", rb(1), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined RISC core, replacing the single-write, two-read array in the decode stage. It provides NRD combinational read ports and two posedge write ports, with same-cycle write-to-read bypass. A per-register busy scoreboard lets decode detect pending writebacks. A post-reset sweep zero-fills the array so no register reads X.

## Interface
Parameters:
- RFW, 5, register address width; depth = 2**RFW
- DW, 32, data width
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- ready  out  1  high once the zero-fill sweep is complete
- raddr  in  NRD*RFW  read addresses; port k = raddr[k*RFW +: RFW]
- rdata  out  NRD*DW  read data; port k = rdata[k*DW +: DW]
- rbusy  out  NRD  port k's register has an outstanding allocation
- we0, we1  in  1 each  write enables (we1 = older pipeline stage, higher priority)
- waddr0, waddr1  in  RFW each  write addresses
- wdata0, wdata1  in  DW each  write data
- alloc  in  1  mark a register busy (issue of a producing instruction)
- alloc_reg  in  RFW  register to mark busy

## Operation
- FSM states:
  - INIT: entered asynchronously on rst_n low. A sweep counter writes 0 to entry cnt each cycle, from 0 to 2**RFW-1. Go to RUN after the last entry.
  - RUN: normal operation. Only reset leaves RUN.
- Reset values: ready=0, sweep counter=0, all busy bits 0, state=INIT. The array itself is not reset; the sweep clears it.
- During INIT:
  - we0, we1 and alloc are ignored.
  - All rdata read 0 and all rbusy read 0.
- Register 0 is hardwired to zero:
  - Reads of address 0 return 0 with rbusy=0.
  - Writes and allocs to register 0 are ignored.
- Write ports:
  - On posedge in RUN, weN with waddrN≠0 writes wdataN.
  - If both ports target the same address, port 1's data is stored.
- Read, per port k (combinational):
  - If raddr_k==0, rdata=0.
  - Else if we1 and waddr1==raddr_k, rdata=wdata1.
  - Else if we0 and waddr0==raddr_k, rdata=wdata0.
  - Else rdata is the array content.
- Scoreboard, on posedge in RUN:
  - A write to reg r clears busy[r].
  - alloc to reg r sets busy[r].
  - If alloc and a write hit the same reg in the same cycle, alloc wins and busy stays 1 (a newer producer is in flight).
- rbusy_k = busy[raddr_k], suppressed to 0 when a write to raddr_k is bypassed this cycle and no alloc targets it.

## Timing
- Read latency is 0 cycles (combinational from raddr/we/waddr/wdata).
- Write latency: data is visible in the array on the cycle after the write edge; it is visible via bypass in the same cycle.
- Sweep length: ready rises on the posedge that writes entry 2**RFW-1, i.e. 2**RFW posedges after rst_n deasserts. For RFW=5 that is 32 cycles.
- rst_n asserted mid-sweep or mid-RUN:
  - ready, busy and the counter clear immediately, with no clock needed.
  - A new full sweep starts after deassertion.
- alloc and busy take effect on the next cycle: rbusy reflects an alloc in the cycle after its edge.
- No backpressure. Caller stalls decode while any used rbusy bit is 1.

## Test plan
- Reset and sweep (RFW=5): hold rst_n low, release.
  - ready must be 0 for 31 cycles and 1 at the 32nd posedge.
  - Afterwards, reads of regs 1..31 return 0x00000000, never X.
- Basic write/read:
  - we0, waddr0=5, wdata0=0xDEADBEEF.
  - The same cycle raddr[0]=5 returns 0xDEADBEEF via bypass.
  - The next cycle it returns the same value from the array.
- Port priority:
  - we0 (r7, 0x11111111) and we1 (r7, 0x22222222) in the same cycle.
  - Bypass and later reads of r7 return 0x22222222.
- Zero register:
  - we1, waddr1=0, wdata1=0xFFFFFFFF, plus alloc reg 0.
  - raddr=0 returns 0 with rbusy=0 on every cycle.
- Scoreboard:
  - alloc r9; the next cycle rbusy for r9 = 1.
  - A write to r9 with simultaneous alloc r9 leaves rbusy = 1.
  - A later write to r9 alone clears it: rbusy is 0 in that write cycle (bypass) and 0 afterwards.
- Mid-operation reset:
  - Assert rst_n low while r9 is busy and r3=0x1234.
  - busy and ready drop immediately.
  - After a new sweep, r3 reads 0 and r9 is not busy.
